// File: rtl/dff_pkg.sv
// Shared constants for the dff_shift_reg register bank: mode encodings and default width.
package dff_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/dff_bit.sv
// Single register cell: 4:1 next-value mux (hold / right neighbour / left neighbour / load),
// synchronous reset to a per-cell value, true and complement outputs.
module dff_bit
    import dff_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] m,
    input  logic       d,
    input  logic       r_in,
    input  logic       l_in,
    input  logic       rst_val,
    output logic       q,
    output logic       nq,
    output logic       q_nxt
);

    logic q_d;
    logic q_q;

    // Unknown enable or mode yields X rather than silently holding.
    always_comb begin
        q_d = q_q;
        case (en)
            1'b0: q_d = q_q;
            1'b1: begin
                case (m)
                    MODE_HOLD: q_d = q_q;
                    MODE_SHR:  q_d = r_in;
                    MODE_SHL:  q_d = l_in;
                    MODE_LOAD: q_d = d;
                    default:   q_d = 1'bx;
                endcase
            end
            default: q_d = 1'bx;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign nq    = ~q_q;
    assign q_nxt = q_d;

endmodule

// File: rtl/dff_shift_reg.sv
// WIDTH-bit shift/load register bank built from dff_bit cells, with optional end-around
// rotation and a registered change-detect flag.
module dff_shift_reg
    import dff_pkg::*;
#(
    parameter int                 WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter bit                 ROTATE    = 1'b0
) (
    input  logic             C,
    input  logic             R,
    input  logic             EN,
    input  logic [1:0]       M,
    input  logic [WIDTH-1:0] D,
    input  logic             SIR,
    input  logic             SIL,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    output logic             SOR,
    output logic             SOL,
    output logic             CHG
);

    logic [WIDTH-1:0] q_vec;
    logic [WIDTH-1:0] nq_vec;
    logic [WIDTH-1:0] nxt_vec;
    logic [WIDTH-1:0] r_nb;
    logic [WIDTH-1:0] l_nb;
    logic             end_r;
    logic             end_l;
    logic             chg_d;
    logic             chg_q;

    // Bits entering at the two ends: wrapped-around bit when rotating, serial input otherwise.
    assign end_r = ROTATE ? q_vec[0]       : SIR;
    assign end_l = ROTATE ? q_vec[WIDTH-1] : SIL;

    generate
        if (WIDTH == 1) begin : g_single
            assign r_nb = end_r;
            assign l_nb = end_l;
        end else begin : g_chain
            assign r_nb = {end_r, q_vec[WIDTH-1:1]};
            assign l_nb = {q_vec[WIDTH-2:0], end_l};
        end
    endgenerate

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_bit u_bit (
            .clk     (C),
            .rst     (R),
            .en      (EN),
            .m       (M),
            .d       (D[i]),
            .r_in    (r_nb[i]),
            .l_in    (l_nb[i]),
            .rst_val (RESET_VAL[i]),
            .q       (q_vec[i]),
            .nq      (nq_vec[i]),
            .q_nxt   (nxt_vec[i])
        );
    end

    always_comb begin
        chg_d = (nxt_vec != q_vec);
    end

    always_ff @(posedge C) begin
        if (R) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign Q   = q_vec;
    assign nQ  = nq_vec;
    assign SOR = q_vec[0];
    assign SOL = q_vec[WIDTH-1];
    assign CHG = chg_q;

endmodule
